tlul_host_master: RTL and testbench
===================================

Name: tlul_host_master

Overview:
- TL-UL initiator (host) that turns a simple req/gnt/rvalid core-side interface into TL-UL A-channel requests and collects D-channel responses.
- Counterpart to the device-side register adapters used by the timer/capture peripherals.
- Used by test harnesses and small DMA/sequencer blocks to drive peripheral register files over the same `tlul_pkg` bus.

Parameters:
- AddrW, 32, request address width (zero-extended to `a_address`).
- MaxOutstanding, 2, maximum in-flight requests (1..15).
- SrcW, 4, width of the `a_source` tag counter (2**SrcW >= MaxOutstanding).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_i  in  1  core request; held with its payload until gnt_o
- we_i  in  1  1=write, 0=read
- addr_i  in  AddrW  byte address, word aligned
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- gnt_o  out  1  request accepted this cycle
- rvalid_o  out  1  one-cycle response strobe
- rdata_o  out  32  response data, valid with rvalid_o
- err_o  out  1  response error (d_error), valid with rvalid_o
- busy_o  out  1  outstanding count != 0 or a_valid high
- proto_err_o  out  1  sticky; D response received with nothing outstanding
- tl_o  out  tlul_pkg::tl_h2d_t  host-to-device channel
- tl_i  in  tlul_pkg::tl_d2h_t  device-to-host channel

Behaviour:
- Clock is clk_i; reset is synchronous and active-low (rst_ni sampled on the rising edge of clk_i).
- Reset values:
  - a_valid=0, all A fields 0.
  - gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, busy_o=0, proto_err_o=0.
  - Outstanding count=0, source counter=0.
  - d_ready=1 at all times, including during reset.
- A-channel register (states A_IDLE, A_PEND):
  - Slot is free when (state==A_IDLE) or (a_valid & a_ready).
  - room = (outstanding + a_valid) < MaxOutstanding, counting a pending beat.
  - Capture when req_i & free & room. gnt_o is combinational and high in the capture cycle.
  - Next cycle: a_valid=1, state A_PEND.
  - Latency is req_i in cycle N -> a_valid in N+1, so back-to-back issue at one beat per cycle is possible when a_ready stays high.
  - A_PEND -> A_IDLE on a_valid & a_ready with no new capture. With a capture in the same cycle, stay in A_PEND with new fields.
  - A fields are stable while a_valid & !a_ready.
- A field encoding:
  - opcode: Get=4 when !we_i; PutFullData=0 when we_i & be_i==4'hF; PutPartialData=1 otherwise.
  - a_size=2; a_mask=be_i (4'hF for Get); a_data=wdata_i (0 for Get).
  - a_address=addr_i; a_source=source counter.
  - a_param=0; user fields at defaults.
- Source counter increments by 1 mod 2**SrcW on each A handshake.
- Outstanding counter:
  - +1 on A handshake; -1 on D handshake (d_valid, since d_ready=1).
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding. When full, gnt_o=0 and req_i must stay high until room frees.
- Responses:
  - d_valid with outstanding>0 (or an A handshake this cycle): next cycle rvalid_o=1, rdata_o=d_data, err_o=d_error. Responses are delivered in arrival order.
  - For a write response, rdata_o=0.
  - rdata_o and err_o hold their value until the next response.
- d_valid with outstanding==0 and no A handshake this cycle:
  - Response is dropped; no rvalid_o.
  - proto_err_o set. It clears only on reset.
- Reset mid-transaction: all state is discarded and a_valid drops on the next edge. Responses arriving after reset count as unexpected.
- addr_i bits [1:0] are passed through unchanged; alignment is the caller's responsibility.

Test Plan:
- Read at addr 0x4, device a_ready=1, d_valid two cycles later with d_data=0xDEADBEEF → gnt_o pulses in cycle 0; a_valid, opcode=4, mask=F, source=0 in cycle 1; rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0.
- Write 0x12345678 to 0x0 with be=4'h3, a_ready held low 3 cycles → opcode=1, mask=3, A fields stable for all 4 cycles; single handshake; write response gives rvalid_o with rdata_o=0.
- Three back-to-back reads, MaxOutstanding=2, no responses → two grants (sources 0,1); third req_i gets gnt_o=0 and busy_o=1. One D response → third granted next cycle with source=2.
- Same-cycle A handshake and D response at outstanding=1 → count stays 1; rvalid_o next cycle; source increments.
- D response with d_error=1 → rvalid_o=1, err_o=1. d_valid injected while idle → no rvalid_o; proto_err_o=1 and sticky until rst_ni=0.
- rst_ni low for one edge while a_valid pending and 2 outstanding → next cycle a_valid=0, busy_o=0, gnt_o available for the next req_i with source=0.

Source files
------------

// File: rtl/tlul_pkg.sv
// Minimal TL-UL bus package: A/D channel opcodes and the host<->device channel structs.
package tlul_pkg;

  parameter int unsigned TlAw  = 32;
  parameter int unsigned TlDw  = 32;
  parameter int unsigned TlAiw = 8;
  parameter int unsigned TlDiw = 1;
  parameter int unsigned TlDbw = TlDw / 8;
  parameter int unsigned TlSzw = 2;
  parameter int unsigned TlUw  = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic             a_valid;
    tl_a_op_e         a_opcode;
    logic [2:0]       a_param;
    logic [TlSzw-1:0] a_size;
    logic [TlAiw-1:0] a_source;
    logic [TlAw-1:0]  a_address;
    logic [TlDbw-1:0] a_mask;
    logic [TlDw-1:0]  a_data;
    logic [TlUw-1:0]  a_user;
    logic             d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    tl_d_op_e         d_opcode;
    logic [2:0]       d_param;
    logic [TlSzw-1:0] d_size;
    logic [TlAiw-1:0] d_source;
    logic [TlDiw-1:0] d_sink;
    logic [TlDw-1:0]  d_data;
    logic [TlUw-1:0]  d_user;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/tlul_host_master.sv
// TL-UL host: converts a req/gnt/rvalid core interface into TL-UL A-channel beats and
// returns D-channel responses in arrival order. Synchronous active-low reset.
module tlul_host_master
  import tlul_pkg::*;
#(
  parameter int unsigned AddrW          = 32,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SrcW           = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       be_i,
  output logic             gnt_o,
  output logic             rvalid_o,
  output logic [31:0]      rdata_o,
  output logic             err_o,
  output logic             busy_o,
  output logic             proto_err_o,
  output tl_h2d_t          tl_o,
  input  tl_d2h_t          tl_i
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam logic [CntW:0] MaxInflight = (CntW + 1)'(MaxOutstanding);

  typedef enum logic [0:0] {
    AIdle,
    APend
  } a_state_e;

  a_state_e          a_state_q;
  tl_a_op_e          a_opcode_q;
  logic [TlAw-1:0]   a_address_q;
  logic [3:0]        a_mask_q;
  logic [31:0]       a_data_q;
  logic [SrcW-1:0]   a_source_q;

  logic [CntW-1:0]   out_q;
  logic [SrcW-1:0]   src_q;
  logic              rvalid_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              proto_err_q;

  logic              a_valid;
  logic              a_hs;
  logic              slot_free;
  logic [CntW:0]     inflight;
  logic              room;
  logic              capture;
  logic              d_expected;
  logic              d_accept;
  logic              d_unexp;

  tl_a_op_e          new_opcode;
  logic [TlAw-1:0]   new_address;
  logic [3:0]        new_mask;
  logic [31:0]       new_data;
  logic [SrcW-1:0]   new_source;

  assign a_valid   = (a_state_q == APend);
  assign a_hs      = a_valid & tl_i.a_ready;
  assign slot_free = (a_state_q == AIdle) | a_hs;
  // A beat still waiting for a_ready already occupies an outstanding slot.
  assign inflight  = {1'b0, out_q} + (CntW + 1)'(a_valid);
  assign room      = inflight < MaxInflight;
  assign capture   = rst_ni & req_i & slot_free & room;
  assign gnt_o     = capture;

  // A response is legal if something is outstanding or its request completes this very cycle.
  assign d_expected = (out_q != '0) | a_hs;
  assign d_accept   = tl_i.d_valid & d_expected;
  assign d_unexp    = tl_i.d_valid & ~d_expected;

  // Encode the A-channel fields for a request being captured this cycle.
  always_comb begin
    new_address              = '0;
    new_address[AddrW-1:0]   = addr_i;
    // The beat handshaking now still owns src_q, so a same-cycle capture takes the next tag.
    new_source               = src_q + SrcW'(a_hs);
    if (!we_i) begin
      new_opcode = Get;
      new_mask   = 4'hF;
      new_data   = '0;
    end else begin
      new_opcode = (be_i == 4'hF) ? PutFullData : PutPartialData;
      new_mask   = be_i;
      new_data   = wdata_i;
    end
  end

  // A-channel FSM: holds one beat stable until a_ready, reloads on same-cycle capture.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      a_state_q   <= AIdle;
      a_opcode_q  <= PutFullData;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      a_source_q  <= '0;
    end else begin
      unique case (a_state_q)
        AIdle: begin
          if (capture) a_state_q <= APend;
        end
        APend: begin
          if (!capture && a_hs) a_state_q <= AIdle;
        end
        default: a_state_q <= AIdle;
      endcase
      if (capture) begin
        a_opcode_q  <= new_opcode;
        a_address_q <= new_address;
        a_mask_q    <= new_mask;
        a_data_q    <= new_data;
        a_source_q  <= new_source;
      end
    end
  end

  // Outstanding/source bookkeeping and registered response delivery.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_q       <= '0;
      src_q       <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (a_hs && !d_accept) begin
        out_q <= out_q + 1'b1;
      end else if (!a_hs && d_accept) begin
        out_q <= out_q - 1'b1;
      end
      if (a_hs) src_q <= src_q + 1'b1;
      rvalid_q <= d_accept;
      if (d_accept) begin
        // Write acks carry no data; whatever the device drives on d_data is ignored.
        rdata_q <= (tl_i.d_opcode == AccessAckData) ? tl_i.d_data : '0;
        err_q   <= tl_i.d_error;
      end
      if (d_unexp) proto_err_q <= 1'b1;
    end
  end

  // Drive the host-to-device channel from the A registers; d_ready is tied high.
  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = a_opcode_q;
    tl_o.a_param   = '0;
    tl_o.a_size    = (a_state_q == APend || a_mask_q != '0) ? 2'd2 : 2'd0;
    tl_o.a_source  = TlAiw'(a_source_q);
    tl_o.a_address = a_address_q;
    tl_o.a_mask    = a_mask_q;
    tl_o.a_data    = a_data_q;
    tl_o.a_user    = '0;
    tl_o.d_ready   = 1'b1;
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign err_o       = err_q;
  assign busy_o      = (out_q != '0) | a_valid;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_tlul_host_master.sv
// Self-checking bench for tlul_host_master: directed scenarios plus a randomized run
// against a queue-based transaction model of host and device.
module tb_tlul_host_master;
  import tlul_pkg::*;

  localparam int unsigned MaxOut = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid, err, busy, proto_err;
  logic [31:0] rdata;
  tl_h2d_t     tl_o;
  tl_d2h_t     tl_i;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [3:0]  src;
  } req_t;

  typedef struct {
    logic        we;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  req_t pend_q[$];
  rsp_t rsp_q[$];

  tlul_host_master #(
    .AddrW(32),
    .MaxOutstanding(MaxOut),
    .SrcW(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_i(req),
    .we_i(we),
    .addr_i(addr),
    .wdata_i(wdata),
    .be_i(be),
    .gnt_o(gnt),
    .rvalid_o(rvalid),
    .rdata_o(rdata),
    .err_o(err),
    .busy_o(busy),
    .proto_err_o(proto_err),
    .tl_o(tl_o),
    .tl_i(tl_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req   = 1'b0;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    be    = '0;
    tl_i  = '0;
    tl_i.a_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    req   = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    n_checks++; if (tl_o.a_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_a_valid: got %b want 0", tl_o.a_valid); end
    n_checks++; if ({tl_o.a_opcode, tl_o.a_address, tl_o.a_mask, tl_o.a_data, tl_o.a_source}
                    !== '0) begin n_fail++;
      $display("FAIL reset_a_fields: got %h want 0",
               {tl_o.a_opcode, tl_o.a_address, tl_o.a_mask, tl_o.a_data, tl_o.a_source}); end
    n_checks++; if (gnt !== 1'b0) begin n_fail++;
      $display("FAIL reset_gnt: got %b want 0", gnt); end
    n_checks++; if ({rvalid, rdata, err, busy, proto_err} !== '0) begin n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {rvalid, rdata, err, busy, proto_err}); end
    n_checks++; if (tl_o.d_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_d_ready: got %b want 1", tl_o.d_ready); end
    req   = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read();
    do_reset();
    req = 1'b1; we = 1'b0; addr = 32'h4;
    #1;
    n_checks++; if (gnt !== 1'b1) begin n_fail++;
      $display("FAIL read_gnt: got %b want 1", gnt); end
    tick();
    req = 1'b0;
    n_checks++; if ({tl_o.a_valid, tl_o.a_opcode, tl_o.a_mask, tl_o.a_source, tl_o.a_address}
                    !== {1'b1, Get, 4'hF, 8'h0, 32'h4}) begin n_fail++;
      $display("FAIL read_abeat: got %h want %h",
               {tl_o.a_valid, tl_o.a_opcode, tl_o.a_mask, tl_o.a_source, tl_o.a_address},
               {1'b1, Get, 4'hF, 8'h0, 32'h4}); end
    tick();
    tl_i.d_valid = 1'b1; tl_i.d_opcode = AccessAckData; tl_i.d_data = 32'hDEADBEEF;
    tl_i.d_error = 1'b0;
    tick();
    tl_i.d_valid = 1'b0;
    n_checks++; if ({rvalid, rdata, err} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin n_fail++;
      $display("FAIL read_resp: got %h want %h", {rvalid, rdata, err},
               {1'b1, 32'hDEADBEEF, 1'b0}); end
    tick();
    n_checks++; if ({rvalid, rdata, busy} !== {1'b0, 32'hDEADBEEF, 1'b0}) begin n_fail++;
      $display("FAIL read_hold: got %h want %h", {rvalid, rdata, busy},
               {1'b0, 32'hDEADBEEF, 1'b0}); end
  endtask

  task automatic test_write_stall();
    do_reset();
    tl_i.a_ready = 1'b0;
    req = 1'b1; we = 1'b1; addr = 32'h0; wdata = 32'h12345678; be = 4'h3;
    #1;
    n_checks++; if (gnt !== 1'b1) begin n_fail++;
      $display("FAIL write_gnt: got %b want 1", gnt); end
    tick();
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) tl_i.a_ready = 1'b1;
      n_checks++;
      if ({tl_o.a_valid, tl_o.a_opcode, tl_o.a_mask, tl_o.a_data, tl_o.a_address}
          !== {1'b1, PutPartialData, 4'h3, 32'h12345678, 32'h0}) begin n_fail++;
        $display("FAIL write_stable[%0d]: got %h want %h", k,
                 {tl_o.a_valid, tl_o.a_opcode, tl_o.a_mask, tl_o.a_data, tl_o.a_address},
                 {1'b1, PutPartialData, 4'h3, 32'h12345678, 32'h0}); end
      tick();
    end
    n_checks++; if ({tl_o.a_valid, busy} !== 2'b01) begin n_fail++;
      $display("FAIL write_single_hs: got %b want 01", {tl_o.a_valid, busy}); end
    tl_i.d_valid = 1'b1; tl_i.d_opcode = AccessAck; tl_i.d_data = 32'hFFFFFFFF;
    tick();
    tl_i.d_valid = 1'b0;
    n_checks++; if ({rvalid, rdata, err} !== {1'b1, 32'h0, 1'b0}) begin n_fail++;
      $display("FAIL write_resp: got %h want %h", {rvalid, rdata, err}, {1'b1, 32'h0, 1'b0}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 1'b1; we = 1'b0; addr = 32'h10;
    #1;
    n_checks++; if (gnt !== 1'b1) begin n_fail++;
      $display("FAIL b2b_gnt0: got %b want 1", gnt); end
    tick();
    addr = 32'h14;
    #1;
    n_checks++; if ({gnt, tl_o.a_source, tl_o.a_address} !== {1'b1, 8'h0, 32'h10}) begin
      n_fail++; $display("FAIL b2b_gnt1: got %h want %h", {gnt, tl_o.a_source, tl_o.a_address},
                         {1'b1, 8'h0, 32'h10}); end
    tick();
    addr = 32'h18;
    #1;
    n_checks++; if ({gnt, busy, tl_o.a_source, tl_o.a_address} !== {2'b01, 8'h1, 32'h14}) begin
      n_fail++; $display("FAIL b2b_full: got %h want %h",
                         {gnt, busy, tl_o.a_source, tl_o.a_address}, {2'b01, 8'h1, 32'h14}); end
    tick();
    tl_i.d_valid = 1'b1; tl_i.d_opcode = AccessAckData; tl_i.d_data = 32'hA;
    #1;
    n_checks++; if ({gnt, tl_o.a_valid, busy} !== 3'b001) begin n_fail++;
      $display("FAIL b2b_wait: got %b want 001", {gnt, tl_o.a_valid, busy}); end
    tick();
    tl_i.d_valid = 1'b0;
    #1;
    n_checks++; if ({gnt, rvalid, rdata} !== {2'b11, 32'hA}) begin n_fail++;
      $display("FAIL b2b_regrant: got %h want %h", {gnt, rvalid, rdata}, {2'b11, 32'hA}); end
    tick();
    req = 1'b0;
    n_checks++; if ({tl_o.a_valid, tl_o.a_source, tl_o.a_address} !== {1'b1, 8'h2, 32'h18})
    begin n_fail++; $display("FAIL b2b_src2: got %h want %h",
                             {tl_o.a_valid, tl_o.a_source, tl_o.a_address},
                             {1'b1, 8'h2, 32'h18}); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    req = 1'b1; we = 1'b0; addr = 32'h40;
    tick();
    req = 1'b0;
    tick();
    req = 1'b1; addr = 32'h44;
    #1;
    n_checks++; if (gnt !== 1'b1) begin n_fail++;
      $display("FAIL same_gnt: got %b want 1", gnt); end
    tick();
    req = 1'b0;
    tl_i.d_valid = 1'b1; tl_i.d_opcode = AccessAckData; tl_i.d_data = 32'h111;
    n_checks++; if ({tl_o.a_valid, tl_o.a_source} !== {1'b1, 8'h1}) begin n_fail++;
      $display("FAIL same_src: got %h want %h", {tl_o.a_valid, tl_o.a_source}, {1'b1, 8'h1}); end
    tick();
    tl_i.d_data = 32'h222;
    n_checks++; if ({rvalid, rdata, busy} !== {1'b1, 32'h111, 1'b1}) begin n_fail++;
      $display("FAIL same_resp: got %h want %h", {rvalid, rdata, busy}, {1'b1, 32'h111, 1'b1});
    end
    tick();
    tl_i.d_valid = 1'b0;
    n_checks++; if ({rvalid, rdata, busy, proto_err} !== {1'b1, 32'h222, 2'b00}) begin n_fail++;
      $display("FAIL same_count: got %h want %h", {rvalid, rdata, busy, proto_err},
               {1'b1, 32'h222, 2'b00}); end
  endtask

  task automatic test_error_proto();
    do_reset();
    req = 1'b1; we = 1'b0; addr = 32'h8;
    tick();
    req = 1'b0;
    tick();
    tl_i.d_valid = 1'b1; tl_i.d_opcode = AccessAckData; tl_i.d_data = 32'h55;
    tl_i.d_error = 1'b1;
    tick();
    tl_i.d_valid = 1'b0;
    n_checks++; if ({rvalid, err, rdata} !== {2'b11, 32'h55}) begin n_fail++;
      $display("FAIL err_resp: got %h want %h", {rvalid, err, rdata}, {2'b11, 32'h55}); end
    tick();
    tl_i.d_valid = 1'b1; tl_i.d_data = 32'h99; tl_i.d_error = 1'b0;
    tick();
    tl_i.d_valid = 1'b0;
    n_checks++; if ({rvalid, proto_err, rdata, err} !== {2'b01, 32'h55, 1'b1}) begin n_fail++;
      $display("FAIL proto_drop: got %h want %h", {rvalid, proto_err, rdata, err},
               {2'b01, 32'h55, 1'b1}); end
    tick(); tick(); tick();
    n_checks++; if (proto_err !== 1'b1) begin n_fail++;
      $display("FAIL proto_sticky: got %b want 1", proto_err); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (proto_err !== 1'b0) begin n_fail++;
      $display("FAIL proto_clear: got %b want 0", proto_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 1'b1; we = 1'b0; addr = 32'h20;
    tick();
    addr = 32'h24;
    tick();
    req = 1'b0; tl_i.a_ready = 1'b0;
    n_checks++; if ({tl_o.a_valid, busy} !== 2'b11) begin n_fail++;
      $display("FAIL mid_setup: got %b want 11", {tl_o.a_valid, busy}); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tl_i.a_ready = 1'b1;
    n_checks++; if ({tl_o.a_valid, busy} !== 2'b00) begin n_fail++;
      $display("FAIL mid_flush: got %b want 00", {tl_o.a_valid, busy}); end
    req = 1'b1; addr = 32'h30;
    #1;
    n_checks++; if (gnt !== 1'b1) begin n_fail++;
      $display("FAIL mid_gnt: got %b want 1", gnt); end
    tick();
    req = 1'b0;
    n_checks++; if ({tl_o.a_valid, tl_o.a_source, tl_o.a_address} !== {1'b1, 8'h0, 32'h30})
    begin n_fail++; $display("FAIL mid_src0: got %h want %h",
                             {tl_o.a_valid, tl_o.a_source, tl_o.a_address},
                             {1'b1, 8'h0, 32'h30}); end
  endtask

  task automatic test_random();
    req_t        cur, b;
    rsp_t        r;
    bit          have_req = 0;
    bit          hs, dv, exp_gnt, exp_rv = 0, exp_err = 0;
    logic [31:0] exp_rd = '0;
    int          out_m = 0;
    int          grants = 0;
    logic [79:0] got_beat, exp_beat;
    tl_a_op_e    exp_op;
    pend_q.delete();
    rsp_q.delete();
    do_reset();
    for (int cyc = 0; cyc < 460; cyc++) begin
      n_checks++;
      if ({tl_o.a_valid, busy} !== {pend_q.size() != 0, (out_m != 0) || (pend_q.size() != 0)})
      begin n_fail++; $display("FAIL rand_state@%0d: got %b want %b", cyc, {tl_o.a_valid, busy},
                               {pend_q.size() != 0, (out_m != 0) || (pend_q.size() != 0)}); end
      n_checks++;
      if ({rvalid, rdata, err} !== {exp_rv, exp_rd, exp_err}) begin n_fail++;
        $display("FAIL rand_resp@%0d: got %h want %h", cyc, {rvalid, rdata, err},
                 {exp_rv, exp_rd, exp_err}); end
      if (!have_req && cyc < 400 && $urandom_range(0, 2) != 0) begin
        cur.we    = 1'($urandom_range(0, 1));
        cur.addr  = $urandom & 32'hFFFF_FFFC;
        cur.wdata = $urandom;
        cur.be    = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
        have_req  = 1;
      end
      req   = have_req;
      we    = cur.we;
      addr  = cur.addr;
      wdata = cur.wdata;
      be    = cur.be;
      tl_i.a_ready = (cyc >= 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      dv = (rsp_q.size() != 0) && (cyc >= 400 || $urandom_range(0, 2) != 0);
      tl_i.d_valid = dv;
      if (dv) begin
        tl_i.d_opcode = rsp_q[0].we ? AccessAck : AccessAckData;
        tl_i.d_data   = rsp_q[0].we ? $urandom : rsp_q[0].data;
        tl_i.d_error  = rsp_q[0].err;
      end
      #1;
      hs = (pend_q.size() != 0) && tl_i.a_ready;
      exp_gnt = have_req && (pend_q.size() == 0 || hs) && (out_m + pend_q.size() < MaxOut);
      n_checks++; if (gnt !== exp_gnt) begin n_fail++;
        $display("FAIL rand_gnt@%0d: got %b want %b", cyc, gnt, exp_gnt); end
      if (hs) begin
        b = pend_q.pop_front();
        exp_op   = !b.we ? Get : ((b.be == 4'hF) ? PutFullData : PutPartialData);
        exp_beat = {exp_op, b.addr, b.we ? b.be : 4'hF, b.we ? b.wdata : 32'h0, 8'(b.src)};
        got_beat = {tl_o.a_opcode, tl_o.a_address, tl_o.a_mask, tl_o.a_data, tl_o.a_source};
        n_checks++; if (got_beat !== exp_beat) begin n_fail++;
          $display("FAIL rand_abeat@%0d: got %h want %h", cyc, got_beat, exp_beat); end
        r.we   = b.we;
        r.data = b.we ? 32'h0 : $urandom;
        r.err  = ($urandom_range(0, 7) == 0);
        rsp_q.push_back(r);
      end
      exp_rv = dv;
      if (dv) begin
        r = rsp_q.pop_front();
        exp_rd  = r.data;
        exp_err = r.err;
      end
      if (exp_gnt) begin
        cur.src = 4'(grants);
        pend_q.push_back(cur);
        grants++;
        have_req = 0;
      end
      out_m = out_m + int'(hs) - int'(dv);
      tick();
    end
    idle_inputs();
    tick();
    n_checks++; if ({busy, proto_err} !== 2'b00) begin n_fail++;
      $display("FAIL rand_drain: got %b want 00", {busy, proto_err}); end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_read();
    test_write_stall();
    test_back_to_back();
    test_same_cycle();
    test_error_proto();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
